data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp.sv | 86 ++++++++
 tb/tb_data_mem_resp.sv | 107 ++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// data_mem_resp: stalling data-memory responder with sync-read RAM and protocol-error flag.
// Define DMEM_MMIO_EN to map 0xFFFF_xxxx to IO (io_out register, cycle counter).
module data_mem_resp #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        cpu_rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
`ifdef DMEM_MMIO_EN
  ,
  output logic [15:0] io_out
`endif
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] ram [1 << ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] rd_q, rd_val, din_q, din_d;
  logic err_q, err_d, aligned, idle, rd_go, wr_go, is_io;
  logic unused_addr;
  assign idx = mem_addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^mem_addr[31:ADDR_WIDTH+2];
`ifdef DMEM_MMIO_EN
  logic [15:0] io_q, io_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  always_comb begin
    is_io = mem_addr[31:16] == 16'hFFFF;
    io_d = (wr_go && is_io && mem_addr[15:0] == 16'h0) ? mem_dout[15:0] : io_q;
    cnt_d = cnt_q + 32'd1;
    sel_d = !rd_go ? sel_q : !is_io ? 2'd0 : mem_addr[15:0] == 16'h0 ? 2'd1 :
            mem_addr[15:0] == 16'h4 ? 2'd2 : 2'd3;
    rd_val = sel_q == 2'd1 ? {16'b0, io_q} : sel_q == 2'd2 ? cnt_q :
             sel_q == 2'd3 ? 32'd0 : rd_q;
  end
  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      io_q <= '0;
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      io_q <= io_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end
  assign io_out = io_q;
`else
  assign is_io = 1'b0;
  assign rd_val = rd_q;
`endif
  always_comb begin
    aligned = mem_addr[1:0] == 2'b00;
    idle = state_q == IDLE;
    rd_go = idle && aligned && mem_ren && !mem_wen;
    wr_go = idle && aligned && mem_wen;
    err_d = err_q || (idle && (mem_ren || mem_wen) && (!aligned || (mem_ren && mem_wen)));
    state_d = rd_go ? RD_WAIT : state_q == RD_WAIT ? RD_DONE : IDLE;
    din_d = state_q == RD_WAIT ? rd_val : din_q;
    mem_stall = !cpu_rst && (rd_go || state_q == RD_WAIT);
  end
  // RAM is never cleared; only the write is blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (wr_go && !is_io && !cpu_rst) ram[idx] <= mem_dout;
    if (rd_go) rd_q <= ram[idx];
  end
  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      din_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q <= din_d;
      err_q <= err_d;
    end
  end
  assign mem_din = din_q;
  assign mem_err = err_q;
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: per-cycle vector table plus hand-written latency/MMIO sequences.
module tb_data_mem_resp;
  logic clk = 1'b0, cpu_rst, mem_ren, mem_wen, mem_stall, mem_err;
  logic [31:0] mem_addr, mem_dout, mem_din;
  int total = 0, bad = 0;
`ifdef DMEM_MMIO_EN
  logic [15:0] io_out;
`endif
  always #5 clk = ~clk;
  data_mem_resp #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .cpu_rst(cpu_rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_stall(mem_stall), .mem_err(mem_err)
`ifdef DMEM_MMIO_EN
    , .io_out(io_out)
`endif
  );
  typedef struct {
    logic rst, ren, wen;
    logic [31:0] addr, dout;
    logic stall;
    logic [31:0] din;
    logic err;
  } vec_t;
  vec_t v [25];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  initial begin
    int n;
    v[0]  = '{1, 1, 0, 32'h10,  32'h0,        0, 32'h0,        0};
    v[1]  = '{0, 0, 1, 32'h10,  32'hDEADBEEF, 0, 32'h0,        0};
    v[2]  = '{0, 1, 0, 32'h10,  32'h0,        1, 32'h0,        0};
    v[3]  = '{0, 1, 0, 32'h10,  32'h0,        1, 32'h0,        0};
    v[4]  = '{0, 1, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 0};
    v[5]  = '{0, 0, 1, 32'h404, 32'hA5A5A5A5, 0, 32'hDEADBEEF, 0};
    v[6]  = '{0, 1, 0, 32'h4,   32'h0,        1, 32'hDEADBEEF, 0};
    v[7]  = '{0, 0, 0, 32'h0,   32'h0,        1, 32'hDEADBEEF, 0};
    v[8]  = '{0, 0, 0, 32'h0,   32'h0,        0, 32'hA5A5A5A5, 0};
    v[9]  = '{0, 1, 0, 32'h402, 32'h0,        0, 32'hA5A5A5A5, 0};
    v[10] = '{0, 0, 0, 32'h0,   32'h0,        0, 32'hA5A5A5A5, 1};
    v[11] = '{0, 1, 1, 32'h20,  32'h12345678, 0, 32'hA5A5A5A5, 1};
    v[12] = '{0, 1, 0, 32'h20,  32'h0,        1, 32'hA5A5A5A5, 1};
    v[13] = '{0, 0, 0, 32'h0,   32'h0,        1, 32'hA5A5A5A5, 1};
    v[14] = '{0, 0, 0, 32'h0,   32'h0,        0, 32'h12345678, 1};
    v[15] = '{0, 1, 0, 32'h10,  32'h0,        1, 32'h12345678, 1};
    v[16] = '{1, 0, 0, 32'h10,  32'h0,        0, 32'h12345678, 1};
    v[17] = '{0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0};
    v[18] = '{0, 1, 0, 32'h20,  32'h0,        1, 32'h0,        0};
    v[19] = '{0, 0, 0, 32'h0,   32'h0,        1, 32'h0,        0};
    v[20] = '{0, 0, 0, 32'h0,   32'h0,        0, 32'h12345678, 0};
    v[21] = '{0, 0, 1, 32'h12,  32'h0,        0, 32'h12345678, 0};
    v[22] = '{0, 1, 0, 32'h10,  32'h0,        1, 32'h12345678, 1};
    v[23] = '{0, 0, 0, 32'h0,   32'h0,        1, 32'h12345678, 1};
    v[24] = '{0, 0, 0, 32'h0,   32'h0,        0, 32'hDEADBEEF, 1};
    cpu_rst = 1; mem_ren = 0; mem_wen = 0; mem_addr = 0; mem_dout = 0;
    @(posedge clk);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      cpu_rst = v[i].rst; mem_ren = v[i].ren; mem_wen = v[i].wen;
      mem_addr = v[i].addr; mem_dout = v[i].dout;
      #1;
      chk($sformatf("v%0d stall", i), {31'b0, mem_stall}, {31'b0, v[i].stall});
      chk($sformatf("v%0d din", i), mem_din, v[i].din);
      chk($sformatf("v%0d err", i), {31'b0, mem_err}, {31'b0, v[i].err});
    end
    // Wrapped read held until stall drops: exactly two stall cycles expected.
    @(negedge clk);
    cpu_rst = 0; mem_ren = 1; mem_wen = 0; mem_addr = 32'h404;
    #1;
    n = 0;
    while (mem_stall && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("lat stall_cycles", n, 2);
    chk("lat din", mem_din, 32'hA5A5A5A5);
    mem_ren = 0;
`ifdef DMEM_MMIO_EN
    @(negedge clk);
    mem_wen = 1; mem_addr = 32'hFFFF0000; mem_dout = 32'h000100C3;
    #1;
    chk("io wr stall", {31'b0, mem_stall}, 32'd0);
    @(negedge clk);
    mem_wen = 0; mem_ren = 1;
    #1;
    chk("io_out", {16'b0, io_out}, 32'h00C3);
    n = 0;
    while (mem_stall && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("io rd stall_cycles", n, 2);
    chk("io rd din", mem_din, 32'h000000C3);
    mem_ren = 0;
`endif
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
